// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: 1 Hz prescaler, hh:mm:ss counters and a button-sequenced set mode.
// Optional alarm (alarm set modes, alarm_arm/alarm_o) is built when CLOCK_ALARM_EN is defined.
module clock_time_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000
`ifdef CLOCK_ALARM_EN
    ,
    parameter int unsigned ALARM_LEN = 30
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
`ifdef CLOCK_ALARM_EN
    input  logic       alarm_arm,
    output logic       alarm_o,
`endif
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [2:0] mode,
    output logic [2:0] blink_mask,
    output logic       tick_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        SET_SEC  = 3'd3
`ifdef CLOCK_ALARM_EN
        ,
        AL_HOUR  = 3'd4,
        AL_MIN   = 3'd5
`endif
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [2:0]    mask_nx;
    logic [PW-1:0] presc;
    logic          mode_q;
    logic          inc_q;
    logic          mode_press;
    logic          inc_press;
    logic          mode_act;
    logic          inc_act;
    logic          tick_now;
    logic [5:0]    sec_nx;
    logic [5:0]    min_nx;
    logic [4:0]    hour_nx;

    function automatic logic [5:0] wrap59(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap23(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    assign mode = state;

    // Press detection, tick qualification, carry chain and mode sequencing
    always_comb begin
        mode_press = mode_btn & ~mode_q;
        inc_press  = inc_btn & ~inc_q;
`ifdef CLOCK_ALARM_EN
        // a press that silences the alarm is consumed
        mode_act   = mode_press & ~alarm_o;
        inc_act    = inc_press & ~alarm_o;
`else
        mode_act   = mode_press;
        inc_act    = inc_press;
`endif
        tick_now   = (state == RUN) && !mode_act && (presc == PW'(TICK_DIV - 1));

        sec_nx  = wrap59(sec);
        min_nx  = (sec == 6'd59) ? wrap59(min) : min;
        hour_nx = (sec == 6'd59 && min == 6'd59) ? wrap23(hour) : hour;

        state_nx = RUN;
        case (state)
            RUN:      state_nx = SET_HOUR;
            SET_HOUR: state_nx = SET_MIN;
            SET_MIN:  state_nx = SET_SEC;
`ifdef CLOCK_ALARM_EN
            SET_SEC:  state_nx = AL_HOUR;
            AL_HOUR:  state_nx = AL_MIN;
            AL_MIN:   state_nx = RUN;
`else
            SET_SEC:  state_nx = RUN;
`endif
            default:  state_nx = RUN;
        endcase

        mask_nx = 3'b000;
        case (state_nx)
            SET_HOUR: mask_nx = 3'b100;
            SET_MIN:  mask_nx = 3'b010;
            SET_SEC:  mask_nx = 3'b001;
`ifdef CLOCK_ALARM_EN
            AL_HOUR:  mask_nx = 3'b100;
            AL_MIN:   mask_nx = 3'b010;
`endif
            default:  mask_nx = 3'b000;
        endcase
    end

    // Mode FSM, prescaler and time counters; a mode press pre-empts everything else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            blink_mask <= 3'b000;
            presc      <= '0;
            tick_o     <= 1'b0;
            sec        <= 6'd0;
            min        <= 6'd0;
            hour       <= 5'd0;
            mode_q     <= 1'b0;
            inc_q      <= 1'b0;
        end else begin
            mode_q <= mode_btn;
            inc_q  <= inc_btn;
            tick_o <= 1'b0;
            if (mode_act) begin
                state      <= state_nx;
                blink_mask <= mask_nx;
                presc      <= '0;
            end else if (state == RUN) begin
                if (tick_now) begin
                    presc  <= '0;
                    tick_o <= 1'b1;
                    sec    <= sec_nx;
                    min    <= min_nx;
                    hour   <= hour_nx;
                end else begin
                    presc <= presc + PW'(1);
                end
            end else if (inc_act) begin
                case (state)
                    SET_HOUR: hour <= wrap23(hour);
                    SET_MIN:  min  <= wrap59(min);
                    SET_SEC:  sec  <= wrap59(sec);
                    default:  ;
                endcase
            end
        end
    end

`ifdef CLOCK_ALARM_EN
    localparam int unsigned AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN + 1) : 1;

    logic [4:0]    alarm_hour;
    logic [5:0]    alarm_min;
    logic [AW-1:0] alarm_cnt;

    // Alarm time registers and alarm_o lifetime (counted in further ticks)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_hour <= 5'd0;
            alarm_min  <= 6'd0;
            alarm_cnt  <= '0;
            alarm_o    <= 1'b0;
        end else begin
            if (inc_act && !mode_act && state == AL_HOUR) alarm_hour <= wrap23(alarm_hour);
            if (inc_act && !mode_act && state == AL_MIN)  alarm_min  <= wrap59(alarm_min);
            if (alarm_o) begin
                if (!alarm_arm || mode_press || inc_press) begin
                    alarm_o <= 1'b0;
                end else if (tick_now) begin
                    if (alarm_cnt == AW'(ALARM_LEN - 1)) alarm_o <= 1'b0;
                    else alarm_cnt <= alarm_cnt + AW'(1);
                end
            end else if (tick_now && alarm_arm && hour_nx == alarm_hour &&
                         min_nx == alarm_min && sec_nx == 6'd0) begin
                alarm_o   <= 1'b1;
                alarm_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: directed steps plus random button traffic
// compared against a seconds-of-day reference model.
module tb_clock_time_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int ALARM_LEN = 3;
`ifdef CLOCK_ALARM_EN
    localparam int NMODES = 6;
`else
    localparam int NMODES = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [2:0] mode;
    logic [2:0] blink_mask;
    logic       tick_o;
`ifdef CLOCK_ALARM_EN
    logic       alarm_arm = 1'b0;
    logic       alarm_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: time as seconds of day, mode as sequence index
    int m_t, m_mode, m_phase, m_ah, m_am;
    bit m_tick, m_mbp, m_ibp;

    always #5 clk = ~clk;

    clock_time_ctrl #(
        .TICK_DIV  (TICK_DIV)
`ifdef CLOCK_ALARM_EN
        ,
        .ALARM_LEN (ALARM_LEN)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
`ifdef CLOCK_ALARM_EN
        .alarm_arm  (alarm_arm),
        .alarm_o    (alarm_o),
`endif
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .mode       (mode),
        .blink_mask (blink_mask),
        .tick_o     (tick_o)
    );

    function automatic int exp_blink(input int md);
        case (md)
            1, 4:    return 4;
            2, 5:    return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int field_val(input int f);
        case (f)
            1:       return m_t / 3600;
            2:       return (m_t / 60) % 60;
            3:       return m_t % 60;
            4:       return m_ah;
            5:       return m_am;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit mb, input bit ib);
        bit mp, ip;
        int h, m, s;
        if (!r) begin
            m_t = 0; m_mode = 0; m_phase = 0; m_tick = 0;
            m_mbp = 0; m_ibp = 0; m_ah = 0; m_am = 0;
            return;
        end
        mp = mb && !m_mbp;
        ip = ib && !m_ibp;
        m_tick = 0;
        if (mp) begin
            m_mode = (m_mode + 1) % NMODES;
            m_phase = 0;
        end else if (m_mode == 0) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_t = (m_t + 1) % 86400;
                m_tick = 1;
            end
        end else if (ip) begin
            h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
            case (m_mode)
                1: h = (h + 1) % 24;
                2: m = (m + 1) % 60;
                3: s = (s + 1) % 60;
                4: m_ah = (m_ah + 1) % 24;
                5: m_am = (m_am + 1) % 60;
                default: ;
            endcase
            m_t = h * 3600 + m * 60 + s;
        end
        m_mbp = mb;
        m_ibp = ib;
    endtask

    task automatic check_all();
        chk("sec",   32'(sec),        32'(m_t % 60));
        chk("min",   32'(min),        32'((m_t / 60) % 60));
        chk("hour",  32'(hour),       32'(m_t / 3600));
        chk("mode",  32'(mode),       32'(m_mode));
        chk("blink", 32'(blink_mask), 32'(exp_blink(m_mode)));
        chk("tick",  32'(tick_o),     32'(m_tick));
    endtask

    task automatic step(input bit mb, input bit ib, input bit r);
        @(negedge clk);
        mode_btn = mb; inc_btn = ib; rst_n = r;
        @(posedge clk);
        model_edge(r, mb, ib);
        #1 check_all();
    endtask

    task automatic press_mode();
        step(1, 0, 1);
        step(0, 0, 1);
    endtask

    task automatic press_inc();
        step(0, 1, 1);
        step(0, 0, 1);
    endtask

    task automatic goto_mode(input int target);
        for (int k = 0; k < 8 && m_mode != target; k++) press_mode();
    endtask

    task automatic inc_to(input int v);
        for (int k = 0; k < 70 && field_val(m_mode) != v; k++) press_inc();
    endtask

    int n, ticks;
    int p_sec, p_min, p_hour;

    initial begin
        // 1: reset, then free run
        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_sec", 32'(sec), 0);
        chk("reset_mode", 32'(mode), 0);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1);
            if (tick_o) ticks++;
        end
        chk("run_ticks", 32'(ticks), 3);
        chk("run_sec3", 32'(sec), 3);

        // 2: set 23:59:59, return to RUN, rollover in one tick
        goto_mode(1); inc_to(23);
        goto_mode(2); inc_to(59);
        goto_mode(3); inc_to(59);
        goto_mode(NMODES - 1);
        step(1, 0, 1);
        n = 1;
        p_sec = 32'(sec); p_min = 32'(min); p_hour = 32'(hour);
        step(0, 0, 1);
        while (!tick_o && n < 10) begin
            p_sec = 32'(sec); p_min = 32'(min); p_hour = 32'(hour);
            step(0, 0, 1);
            n++;
        end
        chk("first_tick_latency", 32'(n), 4);
        chk("pre_roll_time", 32'(p_hour * 3600 + p_min * 60 + p_sec), 86399);
        chk("roll_time", 32'({hour, min, sec}), 0);

        // 3: mode stepping and a held button
        for (int i = 0; i < 4; i++) press_mode();
        goto_mode(0);
        for (int i = 0; i < 10; i++) step(1, 0, 1);
        chk("hold_mode", 32'(mode), 1);
        chk("hold_blink", 32'(blink_mask), 4);
        step(0, 0, 1);

        // 4: hour wrap in SET_HOUR, time frozen
        inc_to(23);
        p_sec = 32'(sec); p_min = 32'(min);
        press_inc();
        chk("hour_wrap", 32'(hour), 0);
        chk("hour_wrap_min", 32'(min), 32'(p_min));
        chk("hour_wrap_sec", 32'(sec), 32'(p_sec));
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1);
            if (tick_o) ticks++;
        end
        chk("set_no_tick", 32'(ticks), 0);
        chk("set_frozen_sec", 32'(sec), 32'(p_sec));

        // 5: simultaneous mode + inc in SET_MIN
        goto_mode(2); inc_to(7);
        step(1, 1, 1);
        chk("simul_mode", 32'(mode), 3);
        chk("simul_min", 32'(min), 7);
        step(0, 0, 1);

        // 6: reset mid-set at 05:06:07
        inc_to(7);
        goto_mode(1); inc_to(5);
        goto_mode(2); inc_to(6);
        goto_mode(3);
        chk("preset_time", 32'({hour, min, sec}), 32'({5'd5, 6'd6, 6'd7}));
        step(0, 0, 0);
        chk("midset_reset_time", 32'({hour, min, sec}), 0);
        chk("midset_reset_mode", 32'(mode), 0);
        chk("midset_reset_blink", 32'(blink_mask), 0);

`ifdef CLOCK_ALARM_EN
        // alarm at 00:01, run from 00:00:59: high for ALARM_LEN ticks, then inc clears it
        for (int rep = 0; rep < 2; rep++) begin
            goto_mode(2); inc_to(0);
            goto_mode(3); inc_to(59);
            goto_mode(4); inc_to(0);
            goto_mode(5); inc_to(1);
            alarm_arm = 1'b1;
            goto_mode(0);
            n = 0;
            while (!alarm_o && n < 20) begin
                step(0, 0, 1);
                n++;
            end
            chk("alarm_fire", 32'(alarm_o), 1);
            chk("alarm_fire_time", 32'({hour, min, sec}), 32'({5'd0, 6'd1, 6'd0}));
            if (rep == 0) begin
                n = 0;
                while (alarm_o && n < 40) begin
                    step(0, 0, 1);
                    n++;
                end
                chk("alarm_len_cycles", 32'(n), 32'(ALARM_LEN * TICK_DIV));
            end else begin
                step(0, 1, 1);
                chk("alarm_inc_clear", 32'(alarm_o), 0);
                step(0, 0, 1);
            end
            alarm_arm = 1'b0;
        end
`endif

        // random button traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 299) != 0));
`ifdef CLOCK_ALARM_EN
            chk("alarm_disarmed", 32'(alarm_o), 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
